// File: rtl/tape_status_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tape_status_pkg
// Description : Shared definitions for the tape status encoder: transport
//               states, overlay activity codes, status word field positions,
//               BCD constants and per-digit BCD increment/decrement helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package tape_status_pkg;

    // Overlay activity codes (glyph indices; the font stops at 11)
    localparam logic [3:0] ACT_IDLE = 4'd0;
    localparam logic [3:0] ACT_PLAY = 4'd1;
    localparam logic [3:0] ACT_STOP = 4'd2;
    localparam logic [3:0] ACT_REW  = 4'd3;
    localparam logic [3:0] ACT_FFWD = 4'd4;
    localparam logic [3:0] ACT_REC  = 4'd10;

    // Status word layout
    localparam int STATUS_W   = 33;
    localparam int REC_EN_BIT = 28;
    localparam int ACT_LSB    = 24;
    localparam int CUR_LSB    = 12;
    localparam int MAX_LSB    = 0;

    localparam logic [11:0] BCD_999 = 12'h999;
    localparam logic [11:0] BCD_000 = 12'h000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_STOP = 3'd2,
        ST_REW  = 3'd3,
        ST_FFWD = 3'd4,
        ST_REC  = 3'd5
    } tape_state_e;

    // 3-digit BCD +1 with a 9->0 carry per digit; holds at 999.
    function automatic logic [11:0] bcd_inc3(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != BCD_999) begin
            if (v[3:0] == 4'd9) begin
                r[3:0] = 4'd0;
                if (v[7:4] == 4'd9) begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[7:4] = v[7:4] + 4'd1;
                end
            end else begin
                r[3:0] = v[3:0] + 4'd1;
            end
        end
        return r;
    endfunction

    // 3-digit BCD -1 with a 0->9 borrow per digit; holds at 000.
    function automatic logic [11:0] bcd_dec3(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != BCD_000) begin
            if (v[3:0] == 4'd0) begin
                r[3:0] = 4'd9;
                if (v[7:4] == 4'd0) begin
                    r[7:4]  = 4'd9;
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[7:4] = v[7:4] - 4'd1;
                end
            end else begin
                r[3:0] = v[3:0] - 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] act_code(input tape_state_e s);
        logic [3:0] a;
        case (s)
            ST_PLAY: a = ACT_PLAY;
            ST_STOP: a = ACT_STOP;
            ST_REW:  a = ACT_REW;
            ST_FFWD: a = ACT_FFWD;
            ST_REC:  a = ACT_REC;
            default: a = ACT_IDLE;
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tape_bcd_counter3.sv
`default_nettype none
// ============================================================================
// Module      : tape_bcd_counter3
// Description : 3-digit BCD up/down counter with load. Saturates at 000 and
//               999. Priority: load > inc > dec.
// Ports       : clk, rst_n (async active-low), inc, dec, load,
//               load_value[11:0] -> value[11:0], at_zero, at_max
// Revision    : 1.0 - initial release
// ============================================================================
module tape_bcd_counter3
    import tape_status_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        dec,
    input  logic        load,
    input  logic [11:0] load_value,
    output logic [11:0] value,
    output logic        at_zero,
    output logic        at_max
);

    logic [11:0] value_q;
    logic [11:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (inc) begin
            value_d = bcd_inc3(value_q);
        end else if (dec) begin
            value_d = bcd_dec3(value_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= BCD_000;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign at_zero = (value_q == BCD_000);
    assign at_max  = (value_q == BCD_999);

endmodule
`default_nettype wire

// File: rtl/tape_status_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tape_status_encoder
// Description : Virtual cassette transport FSM with a 3-digit BCD block
//               counter; produces the registered 33-bit overlay status word.
//               Optional macro TAPE_AUTOREWIND_EN: end of tape in PLAY/FFWD
//               enters REW (down to 000, then STOP) instead of STOP.
// Ports       : clk, reset (async active-low), mounted, wr_protect,
//               cmd_play/stop/rew/ffwd/rec (pulses), block_tick (pulse),
//               max_load, max_value[11:0] (BCD)
//               -> status[32:0] = {4'b0, rec_en, activity[3:0], cur, max},
//                  status_upd (pulse when status changes)
// Revision    : 1.0 - initial release
// ============================================================================
module tape_status_encoder
    import tape_status_pkg::*;
#(
    parameter logic [11:0] MAX_DEFAULT = 12'h999
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                mounted,
    input  logic                wr_protect,
    input  logic                cmd_play,
    input  logic                cmd_stop,
    input  logic                cmd_rew,
    input  logic                cmd_ffwd,
    input  logic                cmd_rec,
    input  logic                block_tick,
    input  logic                max_load,
    input  logic [11:0]         max_value,
    output logic [STATUS_W-1:0] status,
    output logic                status_upd
);

`ifdef TAPE_AUTOREWIND_EN
    localparam tape_state_e EOT_STATE = ST_REW;
`else
    localparam tape_state_e EOT_STATE = ST_STOP;
`endif

    localparam logic [STATUS_W-1:0] STATUS_RESET = {{(STATUS_W-12){1'b0}}, MAX_DEFAULT};

    tape_state_e         state_q, state_d;
    logic [11:0]         max_q, max_d;
    logic                rec_en_q, rec_en_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic                status_upd_q, status_upd_d;

    logic                cur_inc, cur_dec, cur_load;
    logic [11:0]         cur_load_value;
    logic [11:0]         cur_value;
    logic                cur_at_zero, cur_at_max;
    logic [11:0]         cur_next_up, cur_next_dn;

    tape_bcd_counter3 u_cur (
        .clk        (clk),
        .rst_n      (reset),
        .inc        (cur_inc),
        .dec        (cur_dec),
        .load       (cur_load),
        .load_value (cur_load_value),
        .value      (cur_value),
        .at_zero    (cur_at_zero),
        .at_max     (cur_at_max)
    );

    assign cur_next_up = bcd_inc3(cur_value);
    assign cur_next_dn = bcd_dec3(cur_value);

    // Next state, counter control and max register
    always_comb begin
        state_d        = state_q;
        max_d          = max_q;
        cur_inc        = 1'b0;
        cur_dec        = 1'b0;
        cur_load       = 1'b0;
        cur_load_value = BCD_000;

        // Tick effect is decided by the state held before any command.
        if (block_tick && (state_q != ST_IDLE)) begin
            case (state_q)
                ST_PLAY, ST_FFWD: begin
                    if (cur_value == max_q) begin
                        state_d = EOT_STATE;
                    end else begin
                        cur_inc = 1'b1;
                        if (cur_next_up == max_q) begin
                            state_d = EOT_STATE;
                        end
                    end
                end
                ST_REW: begin
                    if (!cur_at_zero) begin
                        cur_dec = 1'b1;
                        if (cur_next_dn == BCD_000) begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_REC: begin
                    if (cur_at_max) begin
                        state_d = ST_STOP;
                    end else begin
                        cur_inc = 1'b1;
                        // Recording past the end extends the tape with it.
                        if (cur_value == max_q) begin
                            max_d = bcd_inc3(max_q);
                        end
                    end
                end
                default: ;
            endcase
        end

        if ((state_q == ST_REW) && cur_at_zero) begin
            state_d = ST_STOP;
        end

        // Packed BCD orders the same as binary, so a plain compare suffices.
        if (max_load && ((state_q == ST_IDLE) || (state_q == ST_STOP))) begin
            max_d = max_value;
            if (cur_value > max_value) begin
                cur_load       = 1'b1;
                cur_load_value = max_value;
            end
        end

        // Only an unmount leads into IDLE, so mounted seen high in IDLE is
        // the rising edge.
        if (state_q == ST_IDLE) begin
            state_d = ST_STOP;
        end else if (cmd_stop) begin
            state_d = ST_STOP;
        end else if (cmd_rec && !wr_protect) begin
            state_d = ST_REC;
        end else if (cmd_play) begin
            state_d = ST_PLAY;
        end else if (cmd_rew) begin
            state_d = ST_REW;
        end else if (cmd_ffwd) begin
            state_d = ST_FFWD;
        end

        if (!mounted) begin
            state_d        = ST_IDLE;
            cur_load       = 1'b1;
            cur_load_value = BCD_000;
        end
    end

    // Status word built from registered state only
    always_comb begin
        rec_en_d                   = mounted & ~wr_protect;
        status_d                   = '0;
        status_d[REC_EN_BIT]       = rec_en_q;
        status_d[ACT_LSB +: 4]     = act_code(state_q);
        status_d[CUR_LSB +: 12]    = cur_value;
        status_d[MAX_LSB +: 12]    = max_q;
        status_upd_d               = (status_d != status_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            max_q        <= MAX_DEFAULT;
            rec_en_q     <= 1'b0;
            status_q     <= STATUS_RESET;
            status_upd_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            max_q        <= max_d;
            rec_en_q     <= rec_en_d;
            status_q     <= status_d;
            status_upd_q <= status_upd_d;
        end
    end

    assign status     = status_q;
    assign status_upd = status_upd_q;

endmodule
`default_nettype wire

// File: tb/tb_tape_status_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tape_status_encoder
// Description : Directed self-checking bench for tape_status_encoder.
//               Expected status words are hand-computed as
//               {rec_en, activity, cur[11:0], max[11:0]} in hex.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_status_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mounted = 1'b0;
    logic        wr_protect = 1'b0;
    logic        cmd_play = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        cmd_rew = 1'b0;
    logic        cmd_ffwd = 1'b0;
    logic        cmd_rec = 1'b0;
    logic        block_tick = 1'b0;
    logic        max_load = 1'b0;
    logic [11:0] max_value = 12'h000;
    logic [32:0] status;
    logic        status_upd;

    int check_cnt = 0;
    int error_cnt = 0;
    int upd_cnt;

    always #5 clk = ~clk;

    tape_status_encoder #(.MAX_DEFAULT(12'h999)) dut (
        .clk        (clk),
        .reset      (reset),
        .mounted    (mounted),
        .wr_protect (wr_protect),
        .cmd_play   (cmd_play),
        .cmd_stop   (cmd_stop),
        .cmd_rew    (cmd_rew),
        .cmd_ffwd   (cmd_ffwd),
        .cmd_rec    (cmd_rec),
        .block_tick (block_tick),
        .max_load   (max_load),
        .max_value  (max_value),
        .status     (status),
        .status_upd (status_upd)
    );

    task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // c = {stop, rec, play, rew, ffwd}
    task automatic cmd(input logic [4:0] c);
        {cmd_stop, cmd_rec, cmd_play, cmd_rew, cmd_ffwd} = c;
        step();
        {cmd_stop, cmd_rec, cmd_play, cmd_rew, cmd_ffwd} = 5'b0;
    endtask

    task automatic ticks(input int n);
        block_tick = 1'b1;
        repeat (n) step();
        block_tick = 1'b0;
    endtask

    task automatic load_max(input logic [11:0] v);
        max_load  = 1'b1;
        max_value = v;
        step();
        max_load  = 1'b0;
    endtask

    task automatic remount();
        mounted = 1'b0;
        step();
        mounted = 1'b1;
        step();
        step();
    endtask

    localparam logic [4:0] C_STOP = 5'b10000;
    localparam logic [4:0] C_REC  = 5'b01000;
    localparam logic [4:0] C_PLAY = 5'b00100;
    localparam logic [4:0] C_REW  = 5'b00010;
    localparam logic [4:0] C_FFWD = 5'b00001;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_status", status, 33'h000000999);
        check_val("reset_upd", {32'b0, status_upd}, 33'h0);
        reset = 1'b1;
        step();
        step();
        check_val("unmounted_idle", status, 33'h000000999);

        // Mount, play 5 blocks
        mounted = 1'b1;
        step();
        step();
        check_val("mount_stop", status, 33'h012000999);
        cmd(C_PLAY);
        ticks(5);
        step();
        check_val("play_5", status, 33'h011005999);

        // stop+play with a tick in PLAY: tick uses PLAY, stop wins
        cmd_stop = 1'b1; cmd_play = 1'b1; block_tick = 1'b1;
        step();
        cmd_stop = 1'b0; cmd_play = 1'b0; block_tick = 1'b0;
        upd_cnt = 0;
        repeat (4) begin
            if (status_upd) upd_cnt++;
            step();
        end
        check_val("stop_play_tick", status, 33'h012006999);
        check_val("upd_pulses", 33'(upd_cnt), 33'd1);

        // Command priority
        cmd(C_REC | C_PLAY);
        step();
        check_val("prio_rec_play", status, 33'h01A006999);
        cmd(C_REW | C_FFWD);
        step();
        check_val("prio_rew_ffwd", status, 33'h013006999);
        cmd(C_PLAY | C_FFWD);
        step();
        check_val("prio_play_ffwd", status, 33'h011006999);
        cmd(C_STOP | C_REC);
        step();
        check_val("prio_stop_rec", status, 33'h012006999);

        // Unmount clears cur and rec_en
        mounted = 1'b0;
        step();
        step();
        check_val("unmount_stop", status, 33'h000000999);
        mounted = 1'b1;
        step();
        step();

        // Short tape: end of tape
        load_max(12'h012);
        cmd(C_PLAY);
        ticks(12);
        step();
`ifdef TAPE_AUTOREWIND_EN
        check_val("eot_autorew", status, 33'h013012012);
        ticks(12);
        step();
        check_val("autorew_done", status, 33'h012000012);
        load_max(12'h005);
        step();
        check_val("max_clamp", status, 33'h012000005);
        cmd(C_PLAY);
        load_max(12'h123);
        step();
        check_val("load_in_play", status, 33'h011000005);
`else
        check_val("eot_stop", status, 33'h012012012);
        load_max(12'h005);
        step();
        check_val("max_clamp", status, 33'h012005005);
        cmd(C_PLAY);
        load_max(12'h123);
        step();
        check_val("load_in_play", status, 33'h011005005);
`endif
        cmd(C_STOP);
        load_max(12'h999);

        // Rewind with borrow and saturation at 000
        remount();
        cmd(C_PLAY);
        ticks(100);
        step();
        check_val("play_100", status, 33'h011100999);
        cmd(C_REW);
        ticks(1);
        step();
        check_val("rew_borrow", status, 33'h013099999);
        ticks(98);
        step();
        check_val("rew_001", status, 33'h013001999);
        ticks(1);
        step();
        check_val("rew_to_000", status, 33'h012000999);
        ticks(1);
        step();
        check_val("stop_hold_000", status, 33'h012000999);

        // Write protect blocks REC
        wr_protect = 1'b1;
        repeat (3) step();
        check_val("wp_rec_en", status, 33'h002000999);
        cmd(C_REC);
        step();
        check_val("wp_rec_ignored", status, 33'h002000999);
        wr_protect = 1'b0;

        // REC past the end, up to 999
        load_max(12'h998);
        cmd(C_PLAY);
        ticks(998);
        step();
`ifdef TAPE_AUTOREWIND_EN
        check_val("play_998", status, 33'h013998998);
`else
        check_val("play_998", status, 33'h012998998);
`endif
        cmd(C_STOP);
        cmd(C_REC);
        ticks(1);
        step();
        check_val("rec_extend", status, 33'h01A999999);
        ticks(1);
        step();
        check_val("rec_sat_999", status, 33'h012999999);

        // Unmount in PLAY, then IDLE ignores inputs
        cmd(C_PLAY);
        step();
        check_val("play_at_max", status, 33'h011999999);
        mounted = 1'b0;
        step();
        step();
        check_val("unmount_play", status, 33'h000000999);
        cmd_play = 1'b1; block_tick = 1'b1;
        step();
        cmd_play = 1'b0; block_tick = 1'b0;
        step();
        check_val("idle_ignores", status, 33'h000000999);

        // Async reset mid-REW
        mounted = 1'b1;
        step();
        step();
        cmd(C_PLAY);
        ticks(3);
        cmd(C_REW);
        ticks(1);
        step();
        check_val("rew_002", status, 33'h013002999);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_reset", status, 33'h000000999);
        check_val("async_reset_upd", {32'b0, status_upd}, 33'h0);
        step();
        reset = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
`default_nettype wire
